// File: rtl/branch_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_update_ctrl
// Description : In-order tracker of predicted branches between IF and EX;
//               retires against EX outcomes, trains the BHT, flags flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [IDX_W-1:0]           fetch_index,
  input  logic                       fetch_pred,
  output logic                       fetch_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_outcome,
  output logic                       upd_valid,
  output logic [IDX_W-1:0]           upd_index,
  output logic                       upd_taken,
  output logic                       flush,
  output logic [$clog2(DEPTH):0]     inflight,
  output logic [CNT_W-1:0]           branch_cnt,
  output logic [CNT_W-1:0]           mispred_cnt,
  output logic                       err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] c_DEPTH   = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [OCC_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_idx  [DEPTH];
  logic              r_pred [DEPTH];

  logic              w_alloc;
  logic              w_resolve;
  logic              w_mispred;
  logic              w_underflow;
  logic [PTR_W-1:0]  w_tail_nxt;

  // Full is judged on the current count only, so a same-cycle pop never frees a slot.
  assign fetch_ready = (r_state == S_RUN) && (r_count < c_DEPTH);
  assign inflight    = r_count;

  assign w_alloc     = fetch_valid && fetch_ready;
  assign w_resolve   = (r_state == S_RUN) && resolve_valid && (r_count != '0);
  assign w_mispred   = w_resolve && (resolve_outcome != r_pred[r_head]);
  assign w_underflow = (r_state == S_RUN) && resolve_valid && (r_count == '0);
  assign w_tail_nxt  = w_alloc ? r_tail + PTR_W'(1) : r_tail;

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_idx[r_tail]  <= fetch_index;
      r_pred[r_tail] <= fetch_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      upd_valid     <= 1'b0;
      upd_index     <= '0;
      upd_taken     <= 1'b0;
      flush         <= 1'b0;
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid <= w_resolve;
      flush     <= w_mispred;
      if (w_resolve) begin
        upd_index <= r_idx[r_head];
        upd_taken <= resolve_outcome;
        if (branch_cnt != c_CNT_MAX) branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (w_mispred && (mispred_cnt != c_CNT_MAX)) mispred_cnt <= mispred_cnt + CNT_W'(1);
      if (w_underflow) err_underflow <= 1'b1;

      case (r_state)
        S_RUN: begin
          r_tail <= w_tail_nxt;
          if (w_mispred) begin
            // Everything younger, including a same-cycle fetch, is wrong-path.
            r_state <= S_FLUSH;
            r_head  <= w_tail_nxt;
            r_count <= '0;
          end else begin
            if (w_resolve) r_head <= r_head + PTR_W'(1);
            if (w_alloc && !w_resolve)      r_count <= r_count + OCC_W'(1);
            else if (!w_alloc && w_resolve) r_count <= r_count - OCC_W'(1);
          end
        end
        S_FLUSH: r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_update_ctrl
// Description : Directed self-checking bench for branch_update_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_update_ctrl;

  localparam int DEPTH = 4;
  localparam int IDX_W = 4;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_valid;
  logic [IDX_W-1:0]  fetch_index;
  logic              fetch_pred;
  logic              fetch_ready;
  logic              resolve_valid;
  logic              resolve_outcome;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_index;
  logic              upd_taken;
  logic              flush;
  logic [2:0]        inflight;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;
  logic              err_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  branch_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_valid     (fetch_valid),
    .fetch_index     (fetch_index),
    .fetch_pred      (fetch_pred),
    .fetch_ready     (fetch_ready),
    .resolve_valid   (resolve_valid),
    .resolve_outcome (resolve_outcome),
    .upd_valid       (upd_valid),
    .upd_index       (upd_index),
    .upd_taken       (upd_taken),
    .flush           (flush),
    .inflight        (inflight),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt),
    .err_underflow   (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cyc(input logic fv, input logic [IDX_W-1:0] fi, input logic fp,
                     input logic rv, input logic ro);
    fetch_valid     = fv;
    fetch_index     = fi;
    fetch_pred      = fp;
    resolve_valid   = rv;
    resolve_outcome = ro;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rdy"},   32'(fetch_ready),   32'd1);
    chk({tag, "_uv"},    32'(upd_valid),     32'd0);
    chk({tag, "_uidx"},  32'(upd_index),     32'd0);
    chk({tag, "_utk"},   32'(upd_taken),     32'd0);
    chk({tag, "_fl"},    32'(flush),         32'd0);
    chk({tag, "_inf"},   32'(inflight),      32'd0);
    chk({tag, "_bc"},    32'(branch_cnt),    32'd0);
    chk({tag, "_mc"},    32'(mispred_cnt),   32'd0);
    chk({tag, "_err"},   32'(err_underflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    chk_reset_state("rst");

    // 1: three fetches, three correct resolves
    cyc(1, 4'd5, 1, 0, 0);
    cyc(1, 4'd6, 1, 0, 0);
    cyc(1, 4'd7, 0, 0, 0);
    chk("t1_inf", 32'(inflight), 32'd3);
    cyc(0, 0, 0, 1, 1);
    chk("t1_uv0", 32'(upd_valid), 32'd1);
    chk("t1_ix0", 32'(upd_index), 32'd5);
    chk("t1_tk0", 32'(upd_taken), 32'd1);
    chk("t1_fl0", 32'(flush),     32'd0);
    cyc(0, 0, 0, 1, 1);
    chk("t1_ix1", 32'(upd_index), 32'd6);
    chk("t1_tk1", 32'(upd_taken), 32'd1);
    chk("t1_fl1", 32'(flush),     32'd0);
    cyc(0, 0, 0, 1, 0);
    chk("t1_uv2", 32'(upd_valid), 32'd1);
    chk("t1_ix2", 32'(upd_index), 32'd7);
    chk("t1_tk2", 32'(upd_taken), 32'd0);
    chk("t1_fl2", 32'(flush),     32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_uvoff", 32'(upd_valid), 32'd0);
    chk("t1_bc", 32'(branch_cnt),  32'd3);
    chk("t1_mc", 32'(mispred_cnt), 32'd0);
    chk("t1_inf0", 32'(inflight),  32'd0);

    // 2: fill to DEPTH, 5th fetch dropped, pop reopens
    for (int i = 1; i <= 4; i++) cyc(1, 4'(i), 0, 0, 0);
    chk("t2_inf4", 32'(inflight),    32'd4);
    chk("t2_rdy0", 32'(fetch_ready), 32'd0);
    cyc(1, 4'd15, 1, 0, 0);
    chk("t2_drop", 32'(inflight),    32'd4);
    // correct resolve with a concurrent fetch while full: only the pop happens
    cyc(1, 4'd14, 1, 1, 0);
    chk("t2_inf3", 32'(inflight),    32'd3);
    chk("t2_rdy1", 32'(fetch_ready), 32'd1);
    chk("t2_ix1",  32'(upd_index),   32'd1);
    for (int i = 2; i <= 4; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk($sformatf("t2_ix%0d", i), 32'(upd_index), 32'(i));
      chk($sformatf("t2_fl%0d", i), 32'(flush), 32'd0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("t2_empty", 32'(inflight), 32'd0);
    chk("t2_bc", 32'(branch_cnt), 32'd7);

    // 3: mispredict with three in flight
    cyc(1, 4'd10, 1, 0, 0);
    cyc(1, 4'd11, 1, 0, 0);
    cyc(1, 4'd12, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t3_fl",  32'(flush),       32'd1);
    chk("t3_uv",  32'(upd_valid),   32'd1);
    chk("t3_ix",  32'(upd_index),   32'd10);
    chk("t3_tk",  32'(upd_taken),   32'd0);
    chk("t3_inf", 32'(inflight),    32'd0);
    chk("t3_rdy0", 32'(fetch_ready), 32'd0);
    // resolve during FLUSH is ignored and not an underflow
    cyc(0, 0, 0, 1, 1);
    chk("t3_fl2",  32'(flush),       32'd0);
    chk("t3_uv2",  32'(upd_valid),   32'd0);
    chk("t3_rdy1", 32'(fetch_ready), 32'd1);
    chk("t3_mc",   32'(mispred_cnt), 32'd1);
    chk("t3_bc",   32'(branch_cnt),  32'd8);
    chk("t3_err",  32'(err_underflow), 32'd0);

    // 4: simultaneous fetch + resolve
    cyc(1, 4'd2, 1, 0, 0);
    cyc(1, 4'd3, 1, 0, 0);
    cyc(1, 4'd9, 0, 1, 1);
    chk("t4_inf2", 32'(inflight),  32'd2);
    chk("t4_ix",   32'(upd_index), 32'd2);
    chk("t4_fl0",  32'(flush),     32'd0);
    cyc(1, 4'd13, 1, 1, 0);
    chk("t4_fl1",  32'(flush),     32'd1);
    chk("t4_ix2",  32'(upd_index), 32'd3);
    chk("t4_inf0", 32'(inflight),  32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_inf0b", 32'(inflight),  32'd0);
    chk("t4_mc",    32'(mispred_cnt), 32'd2);
    chk("t4_bc",    32'(branch_cnt),  32'd10);

    // 5: underflow then wrap
    cyc(0, 0, 0, 1, 1);
    chk("t5_err", 32'(err_underflow), 32'd1);
    chk("t5_uv",  32'(upd_valid),     32'd0);
    chk("t5_fl",  32'(flush),         32'd0);
    chk("t5_bc",  32'(branch_cnt),    32'd10);
    cyc(0, 0, 0, 0, 0);
    chk("t5_sticky", 32'(err_underflow), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 4'(i + 3), 1'(i), 0, 0);
      cyc(0, 0, 0, 1, 1'(i));
      chk($sformatf("t5_w%0d_ix", i), 32'(upd_index), 32'(i + 3));
      chk($sformatf("t5_w%0d_tk", i), 32'(upd_taken), 32'(i & 1));
      chk($sformatf("t5_w%0d_fl", i), 32'(flush), 32'd0);
    end
    cyc(0, 0, 0, 0, 0);
    chk("t5_bc20", 32'(branch_cnt), 32'd20);
    chk("t5_mc2",  32'(mispred_cnt), 32'd2);

    // 6: reset with entries in flight and a mispredicting resolve pending
    cyc(1, 4'd4, 1, 0, 0);
    cyc(1, 4'd5, 0, 0, 0);
    chk("t6_inf2", 32'(inflight), 32'd2);
    rst = 1'b1;
    cyc(0, 0, 0, 1, 0);
    rst = 1'b0;
    chk_reset_state("t6");
    cyc(0, 0, 0, 0, 0);
    chk("t6_uv", 32'(upd_valid), 32'd0);
    chk("t6_fl", 32'(flush),     32'd0);
    chk("t6_inf", 32'(inflight), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
